// File: rtl/fractal_sync_burst_sched.sv
// fractal_sync_burst_sched
//
// Round-robin burst scheduler. It drains IN_PORTS first-word-fall-through
// FIFOs onto one registered valid/ready output link. A port that holds the
// grant may keep it for up to MAX_BURST consecutive grants while others
// wait. This trades some fairness for locality.
//
// Parameters:
//   IN_PORTS   number of input FIFO ports (> 0)
//   arbiter_t  element type carried from the FIFOs to the output
//   MAX_BURST  max consecutive grants to one port (> 0), 1 = pure round-robin
//
// Ports:
//   clk_i      clock, rising edge
//   rst_ni     asynchronous active-low reset
//   pop_o      per-port pop strobe, asserted only for the granted port
//   empty_i    per-port FIFO empty flag
//   element_i  per-port FIFO head element (valid while empty_i is low)
//   valid_o    element_o holds a valid element
//   ready_i    downstream accepts element_o this cycle
//   element_o  registered output element

module fractal_sync_burst_sched #(
   parameter int unsigned IN_PORTS  = 4,
   parameter type         arbiter_t = logic,
   parameter int unsigned MAX_BURST = 2
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   output logic     pop_o     [IN_PORTS],
   input  logic     empty_i   [IN_PORTS],
   input  arbiter_t element_i [IN_PORTS],
   output logic     valid_o,
   input  logic     ready_i,
   output arbiter_t element_o
);

   localparam int unsigned OWNER_W = (IN_PORTS > 1) ? $clog2(IN_PORTS) : 1;
   localparam int unsigned CNT_W   = $clog2(MAX_BURST + 1);

   logic [OWNER_W-1:0]  owner;
   logic [CNT_W-1:0]    burst_cnt;

   logic                load;
   logic [IN_PORTS-1:0] req;
   logic                grant_valid;
   logic                keep;
   logic                found;
   logic [OWNER_W-1:0]  grant_idx;
   logic [OWNER_W:0]    scan_sum;
   logic [OWNER_W-1:0]  scan_idx;

   // Grant selection. burst_cnt is zero only straight out of reset. That
   // case is treated as "no burst in progress", so the first grant comes
   // from the scan starting at port 0. It is not a keep of the reset owner.
   // The scan covers all IN_PORTS positions, so the last candidate is owner
   // itself. That lets a lone requester restart its burst without a bubble.
   always_comb begin
      load        = ~valid_o | ready_i;
      grant_valid = 1'b0;
      keep        = 1'b0;
      found       = 1'b0;
      grant_idx   = owner;
      scan_sum    = '0;
      scan_idx    = '0;
      for (int i = 0; i < int'(IN_PORTS); i++) begin
         req[i] = ~empty_i[i];
      end
      if (load && (|req)) begin
         grant_valid = 1'b1;
         if (req[owner] && (burst_cnt != '0) && (burst_cnt < CNT_W'(MAX_BURST))) begin
            keep = 1'b1;
         end else begin
            for (int k = 1; k <= int'(IN_PORTS); k++) begin
               scan_sum = {1'b0, owner} + (OWNER_W+1)'(k);
               if (scan_sum >= (OWNER_W+1)'(IN_PORTS)) begin
                  scan_sum = scan_sum - (OWNER_W+1)'(IN_PORTS);
               end
               scan_idx = scan_sum[OWNER_W-1:0];
               if (!found && req[scan_idx]) begin
                  found     = 1'b1;
                  grant_idx = scan_idx;
               end
            end
         end
      end
   end

   // Pop strobes are gated by rst_ni. No FIFO is consumed while the
   // output register is held in reset.
   always_comb begin
      for (int i = 0; i < int'(IN_PORTS); i++) begin
         pop_o[i] = rst_ni & grant_valid & (grant_idx == OWNER_W'(i));
      end
   end

   // Output register and arbitration state. Nothing moves while the
   // register holds an element that the consumer has not taken.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_o   <= 1'b0;
         element_o <= '0;
         owner     <= OWNER_W'(IN_PORTS - 1);
         burst_cnt <= '0;
      end else if (load) begin
         if (grant_valid) begin
            valid_o   <= 1'b1;
            element_o <= element_i[grant_idx];
            owner     <= grant_idx;
            burst_cnt <= keep ? (burst_cnt + CNT_W'(1)) : CNT_W'(1);
         end else begin
            valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fractal_sync_burst_sched.sv
// tb_fractal_sync_burst_sched
//
// Self-checking bench for fractal_sync_burst_sched with IN_PORTS=4 and
// MAX_BURST=2. The element type is widened to 8 bits so that the port and
// order of each element are visible on element_o.
// The bench has two parts:
//   - A table of per-cycle vectors that fixes the empty flags, ready_i and
//     element values directly, with hand-computed pop/valid/element results.
//   - Queue-backed FIFO sequences for the multi-cycle cases: lone requester,
//     backpressure, starvation bound, and reset mid-stream.

module tb_fractal_sync_burst_sched;

   logic       clk_i;
   logic       rst_ni;
   logic       pop_o     [4];
   logic       empty_i   [4];
   logic [7:0] element_i [4];
   logic       valid_o;
   logic       ready_i;
   logic [7:0] element_o;

   logic [3:0] pop_vec;
   logic [3:0] empty_vec;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [3:0] empty;
      logic       ready;
      logic [3:0] exp_pop;
      logic       exp_valid;
      logic [7:0] exp_elem;
   } vec_t;

   vec_t vecs [23];

   logic [7:0] q [4][$];

   fractal_sync_burst_sched #(
      .IN_PORTS  (4),
      .arbiter_t (logic [7:0]),
      .MAX_BURST (2)
   ) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .pop_o     (pop_o),
      .empty_i   (empty_i),
      .element_i (element_i),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .element_o (element_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         pop_vec[i]   = pop_o[i];
         empty_vec[i] = empty_i[i];
      end
   end

   // Count one comparison, and report it if the DUT value differs.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
      n_cmp++;
      if (actual !== required) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, actual, required, $time);
      end
   endtask

   task automatic set_empty(input logic [3:0] mask);
      for (int p = 0; p < 4; p++) begin
         empty_i[p] = mask[p];
      end
   endtask

   // Apply one table vector. Element values encode port and row as
   // 16*(port+1)+row. Pops are checked just before the edge, and the
   // output register is checked just after it.
   task automatic applyStimulus(input int r);
      @(negedge clk_i);
      set_empty(vecs[r].empty);
      for (int p = 0; p < 4; p++) begin
         element_i[p] = 8'(16 * (p + 1) + r);
      end
      ready_i = vecs[r].ready;
      #1;
      checkOutput($sformatf("vec%0d_pop", r), 32'(pop_vec), 32'(vecs[r].exp_pop));
      @(posedge clk_i);
      #1;
      checkOutput($sformatf("vec%0d_valid", r), 32'(valid_o), 32'(vecs[r].exp_valid));
      if (vecs[r].exp_valid) begin
         checkOutput($sformatf("vec%0d_elem", r), 32'(element_o), 32'(vecs[r].exp_elem));
      end
   endtask

   // Run one cycle with the FIFO heads taken from the queues. The queues
   // are popped after the edge for every port that was strobed.
   task automatic q_step(input logic rdy, output logic [3:0] popped);
      @(negedge clk_i);
      for (int p = 0; p < 4; p++) begin
         empty_i[p]   = (q[p].size() == 0);
         element_i[p] = (q[p].size() != 0) ? q[p][0] : 8'h00;
      end
      ready_i = rdy;
      #1;
      popped = pop_vec;
      checkOutput("pop_on_empty", 32'(popped & empty_vec), 32'h0);
      @(posedge clk_i);
      #1;
      for (int p = 0; p < 4; p++) begin
         if (popped[p] && q[p].size() != 0) begin
            void'(q[p].pop_front());
         end
      end
   endtask

   initial begin
      logic [3:0] popped;
      int         grants;
      logic       seen3;
      int         exp_cnt [5];

      vecs[0]  = '{4'b0000, 1'b1, 4'b0001, 1'b1, 8'h10};
      vecs[1]  = '{4'b0000, 1'b1, 4'b0001, 1'b1, 8'h11};
      vecs[2]  = '{4'b0000, 1'b1, 4'b0010, 1'b1, 8'h22};
      vecs[3]  = '{4'b0000, 1'b1, 4'b0010, 1'b1, 8'h23};
      vecs[4]  = '{4'b0000, 1'b1, 4'b0100, 1'b1, 8'h34};
      vecs[5]  = '{4'b0000, 1'b1, 4'b0100, 1'b1, 8'h35};
      vecs[6]  = '{4'b0000, 1'b1, 4'b1000, 1'b1, 8'h46};
      vecs[7]  = '{4'b0000, 1'b1, 4'b1000, 1'b1, 8'h47};
      vecs[8]  = '{4'b0000, 1'b1, 4'b0001, 1'b1, 8'h18};
      vecs[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 8'h18};
      vecs[10] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 8'h18};
      vecs[11] = '{4'b0000, 1'b1, 4'b0001, 1'b1, 8'h1B};
      vecs[12] = '{4'b1110, 1'b1, 4'b0001, 1'b1, 8'h1C};
      vecs[13] = '{4'b1110, 1'b1, 4'b0001, 1'b1, 8'h1D};
      vecs[14] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00};
      vecs[15] = '{4'b0111, 1'b1, 4'b1000, 1'b1, 8'h4F};
      vecs[16] = '{4'b1101, 1'b0, 4'b0000, 1'b1, 8'h4F};
      vecs[17] = '{4'b1101, 1'b1, 4'b0010, 1'b1, 8'h31};
      vecs[18] = '{4'b1001, 1'b1, 4'b0010, 1'b1, 8'h32};
      vecs[19] = '{4'b1001, 1'b1, 4'b0100, 1'b1, 8'h43};
      vecs[20] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 8'h43};
      vecs[21] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00};
      vecs[22] = '{4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00};

      // Reset held with every FIFO non-empty: no pops, output cleared.
      rst_ni  = 1'b0;
      ready_i = 1'b1;
      set_empty(4'b0000);
      for (int p = 0; p < 4; p++) begin
         element_i[p] = 8'hF0 + 8'(p);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_i);
         checkOutput("rst_pop", 32'(pop_vec), 32'h0);
         checkOutput("rst_valid", 32'(valid_o), 32'h0);
         checkOutput("rst_elem", 32'(element_o), 32'h0);
      end

      // Idle: release reset with all FIFOs empty.
      set_empty(4'b1111);
      rst_ni = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk_i);
         #1;
         checkOutput("idle_pop", 32'(pop_vec), 32'h0);
         checkOutput("idle_valid", 32'(valid_o), 32'h0);
         checkOutput("idle_elem", 32'(element_o), 32'h0);
      end

      // Reset again while every port requests.
      @(negedge clk_i);
      set_empty(4'b0000);
      rst_ni = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #1;
         checkOutput("rst2_pop", 32'(pop_vec), 32'h0);
         checkOutput("rst2_valid", 32'(valid_o), 32'h0);
         checkOutput("rst2_elem", 32'(element_o), 32'h0);
         @(negedge clk_i);
      end
      set_empty(4'b1111);
      rst_ni = 1'b1;

      $display("[TB] table vectors");
      for (int r = 0; r < 23; r++) begin
         applyStimulus(r);
      end

      // Lone requester: five elements on port 1 with no bubble. The burst
      // counter restarts every MAX_BURST grants.
      $display("[TB] lone requester");
      exp_cnt = '{1, 2, 1, 2, 1};
      for (int k = 0; k < 5; k++) begin
         q[1].push_back(8'hA0 + 8'(k));
      end
      for (int k = 0; k < 5; k++) begin
         q_step(1'b1, popped);
         checkOutput("lone_pop", 32'(popped), 32'h2);
         checkOutput("lone_valid", 32'(valid_o), 32'h1);
         checkOutput("lone_elem", 32'(element_o), 32'hA0 + 32'(k));
         checkOutput("lone_burst_cnt", 32'(dut.burst_cnt), 32'(exp_cnt[k]));
      end
      q_step(1'b1, popped);
      checkOutput("lone_drain_valid", 32'(valid_o), 32'h0);

      // Backpressure: port 2 only, stalled for 5 cycles after the first load.
      $display("[TB] backpressure");
      q[2].push_back(8'hB0);
      q[2].push_back(8'hB1);
      q_step(1'b1, popped);
      checkOutput("bp_first_pop", 32'(popped), 32'h4);
      checkOutput("bp_first_elem", 32'(element_o), 32'hB0);
      for (int c = 0; c < 5; c++) begin
         q_step(1'b0, popped);
         checkOutput("bp_stall_pop", 32'(popped), 32'h0);
         checkOutput("bp_stall_valid", 32'(valid_o), 32'h1);
         checkOutput("bp_stall_elem", 32'(element_o), 32'hB0);
      end
      q_step(1'b1, popped);
      checkOutput("bp_resume_pop", 32'(popped), 32'h4);
      checkOutput("bp_resume_elem", 32'(element_o), 32'hB1);
      q_step(1'b1, popped);
      checkOutput("bp_end_pop", 32'(popped), 32'h0);
      checkOutput("bp_end_valid", 32'(valid_o), 32'h0);

      // Starvation bound: port 0 always requests, and port 3 joins at
      // cycle 10. It must be served within MAX_BURST+1 grants.
      $display("[TB] starvation bound");
      for (int k = 0; k < 40; k++) begin
         q[0].push_back(8'h60 + 8'(k));
      end
      grants = 0;
      seen3  = 1'b0;
      for (int c = 0; c < 30; c++) begin
         if (c == 10) begin
            q[3].push_back(8'hE0);
         end
         q_step(1'b1, popped);
         if (c >= 10 && !seen3 && popped != 4'h0) begin
            grants++;
         end
         if (popped[3]) begin
            seen3 = 1'b1;
            checkOutput("starve_elem", 32'(element_o), 32'hE0);
         end
      end
      checkOutput("starve_seen", 32'(seen3), 32'h1);
      checkOutput("starve_within_bound", 32'(grants <= 3), 32'h1);
      for (int p = 0; p < 4; p++) begin
         q[p].delete();
      end
      q_step(1'b1, popped);
      checkOutput("starve_drain_valid", 32'(valid_o), 32'h0);

      // Reset mid-stream: a port 1 element is held under backpressure when
      // reset hits. It must vanish, and the restart must pick port 1.
      $display("[TB] reset mid-stream");
      q[1].push_back(8'hC0);
      q_step(1'b0, popped);
      checkOutput("mid_load_pop", 32'(popped), 32'h2);
      checkOutput("mid_load_elem", 32'(element_o), 32'hC0);
      q[1].push_back(8'hC1);
      q[2].push_back(8'hD0);
      @(negedge clk_i);
      for (int p = 0; p < 4; p++) begin
         empty_i[p]   = (q[p].size() == 0);
         element_i[p] = (q[p].size() != 0) ? q[p][0] : 8'h00;
      end
      ready_i = 1'b0;
      #2;
      rst_ni = 1'b0;
      #1;
      checkOutput("mid_rst_valid", 32'(valid_o), 32'h0);
      checkOutput("mid_rst_pop", 32'(pop_vec), 32'h0);
      @(posedge clk_i);
      #1;
      checkOutput("mid_rst_hold_valid", 32'(valid_o), 32'h0);
      checkOutput("mid_rst_hold_pop", 32'(pop_vec), 32'h0);
      rst_ni = 1'b1;
      q_step(1'b1, popped);
      checkOutput("mid_restart_pop", 32'(popped), 32'h2);
      checkOutput("mid_restart_valid", 32'(valid_o), 32'h1);
      checkOutput("mid_restart_elem", 32'(element_o), 32'hC1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
